mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Two-requester arbiter and access sequencer for the single shared memory of the multi-cycle MIPS core. It shares one memory port between the core's memory interface (fetch, load, store) and a loader/debug port that preloads or inspects memory. It sequences each access over a programmable memory latency and returns a one-cycle `ready` pulse per access, which the controller uses as a stall/advance condition.

## Interface
- `AW`, 16, address width (word address).
- `DW`, 16, data width.
- `LAT`, 1, memory access cycles (1..15); `mem_rdata` is valid in the last cycle of the access.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_req` in 1: core access request (MemRead|MemWrite).
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: core address.
- `cpu_wdata` in DW: core write data.
- `cpu_rdata` out DW: registered read data, held until the next core read completes.
- `cpu_ready` out 1: one-cycle completion pulse for a core access.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_rdata`, `ldr_ready`: same meaning and widths as the core port signals, for the loader port.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data.
- `gnt_ldr` out 1: 1 while the loader owns the current access (status only).

## Operation
- FSM states:
  - IDLE: arbitrate requests.
  - ACCESS: drive memory for LAT cycles.
  - DONE: assert the `ready` pulse.
- IDLE:
  - No request: stay in IDLE.
  - Request present: latch the winner and its `we`/`addr`/`wdata` into internal registers, then go to ACCESS.
- Arbitration is round-robin using a `last` bit:
  - A sole requester wins.
  - When both request, the port not in `last` wins.
  - `last` updates to the winner on each grant.
  - Reset value of `last` is loader, so the core wins the first tie.
- ACCESS:
  - `mem_en`=1.
  - `mem_we`, `mem_addr`, `mem_wdata` are driven from the latched registers.
  - A 4-bit down-counter is loaded with LAT-1 on grant.
  - When the counter is 0, sample `mem_rdata` into the winner's `rdata` register (reads only) and go to DONE.
- DONE:
  - Winner's `ready`=1 for exactly one cycle.
  - `mem_en`=0.
  - Next state is IDLE.
- Write access: the winner's `rdata` register is unchanged.
- Request fields are latched at grant. Changes to them after grant do not affect the access in flight.
- A requester holds `req` until it sees `ready`.
  - `req` still high in the cycle after `ready` is a new request.
  - `req` dropped mid-access does not abort the access; `ready` is still pulsed.
- The loser's request stays pending and wins the next arbitration, because `last` now points at the other port.
- Reset values: `cpu_rdata`=`ldr_rdata`=0, `cpu_ready`=`ldr_ready`=0, `mem_en`=`mem_we`=0, `mem_addr`=`mem_wdata`=0, `gnt_ldr`=0, state IDLE, counter 0.
- Reset mid-access: the access is abandoned immediately (asynchronous). No `ready` is issued and `mem_en` drops without waiting for a clock.

## Timing
- Request seen high in IDLE at edge t (counting edges with the request stable from before t).
  - ACCESS occupies edges t+1 .. t+LAT, with `mem_en` high for LAT cycles.
  - `ready` is high between edges t+LAT and t+LAT+1.
  - `rdata` is valid from the same edge as `ready` onward.
- Throughput: one access per LAT+2 cycles, because IDLE always costs one cycle after DONE.
- `mem_*` outputs are registered/decoded from state only, with no combinational path from `*_req` to `mem_*`.
- `*_ready` is decoded from state plus the latched grant bit. It never depends combinationally on `*_req`.

## Test plan
- Reset then single core read: LAT=1, `cpu_req`=1, `cpu_addr`=0x0004, memory returns 0x1234.
  - `mem_en` is high 1 cycle with `mem_addr`=0x0004.
  - `cpu_ready` pulses exactly once, 2 cycles after the request is seen.
  - `cpu_rdata`=0x1234 and holds; `ldr_ready` stays 0.
- Loader write, LAT=3: `ldr_addr`=0x0010, `ldr_wdata`=0xBEEF, `ldr_we`=1.
  - `mem_we`=`mem_en`=1 for exactly 3 cycles; `gnt_ldr`=1 during the access.
  - `ldr_ready` pulses once; `ldr_rdata` is unchanged.
- Simultaneous requests held continuously, LAT=1.
  - Grant order is core, loader, core, loader.
  - One `ready` pulse every 3 cycles, alternating ports; no starvation over 8 accesses.
- Field change after grant: `cpu_addr` changes from 0x0020 to 0x0030 one cycle after grant.
  - `mem_addr` stays 0x0020 for the whole access.
- Request dropped mid-access: `cpu_req` is deasserted during ACCESS.
  - `cpu_ready` still pulses once, then the FSM returns to IDLE with no further access.
- Reset mid-access: `rst` asserted in the second cycle of a LAT=3 access.
  - `mem_en` drops before the next edge and no `ready` is issued.
  - After release, `last` is loader again, so a tie grants the core first.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - two-port round-robin arbiter and latency sequencer for the shared MIPS memory
module mips_mem_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 16,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt_ldr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t          state;
  state_t          state_nx;
  logic [3:0]      cnt;
  logic            own_ldr;
  logic            last_ldr;
  logic            pick_ldr;
  logic            any_req;
  logic            acc_we;
  logic [AW-1:0]   acc_addr;
  logic [DW-1:0]   acc_wdata;

  // Round-robin pick: a sole requester wins; on a tie the port not served last wins.
  always_comb begin
    any_req  = cpu_req | ldr_req;
    pick_ldr = ldr_req & (~cpu_req | ~last_ldr);
  end

  // Next-state: IDLE arbitrates, ACCESS runs the latency counter, DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset abandons any access in flight without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Grant latching, latency countdown and read-data capture into the owner's register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 4'd0;
      own_ldr   <= 1'b0;
      last_ldr  <= 1'b1;
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        own_ldr   <= pick_ldr;
        last_ldr  <= pick_ldr;
        acc_we    <= pick_ldr ? ldr_we    : cpu_we;
        acc_addr  <= pick_ldr ? ldr_addr  : cpu_addr;
        acc_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
        cnt       <= CNT_INIT;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == ACCESS && cnt == 4'd0 && !acc_we) begin
        if (own_ldr) begin
          ldr_rdata <= mem_rdata;
        end else begin
          cpu_rdata <= mem_rdata;
        end
      end
    end
  end

  // Outputs decode from state and latched grant only, never from the live requests.
  always_comb begin
    mem_en    = (state == ACCESS);
    mem_we    = (state == ACCESS) & acc_we;
    mem_addr  = acc_addr;
    mem_wdata = acc_wdata;
    cpu_ready = (state == DONE) & ~own_ldr;
    ldr_ready = (state == DONE) & own_ldr;
    gnt_ldr   = (state != IDLE) & own_ldr;
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - scoreboard bench for mips_mem_arbiter at LAT=1 and LAT=3
module tb_mips_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;

  logic [15:0] a_cpu_rdata, a_ldr_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_cpu_ready, a_ldr_ready, a_mem_en, a_mem_we, a_gnt_ldr;
  logic [15:0] b_cpu_rdata, b_ldr_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_cpu_ready, b_ldr_ready, b_mem_en, b_mem_we, b_gnt_ldr;

  logic [15:0] s_cpu_rdata, s_ldr_rdata, s_mem_addr, s_mem_wdata;
  logic        s_cpu_ready, s_ldr_ready, s_mem_en, s_mem_we, s_gnt_ldr;

  logic [15:0] phys [0:255];
  bit          written [0:255];
  logic [15:0] ref_mem [0:255];
  logic [15:0] last_rd [0:1][0:1];

  exp_t cq[$];
  exp_t lq[$];
  int   order[$];
  int   rcyc[$];
  int   cyc;
  int   n_checks;
  int   n_fails;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h04) ? 16'h1234 : {a, ~a};
  endfunction

  mips_mem_arbiter #(.AW(16), .DW(16), .LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req & ~sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ready(a_cpu_ready),
    .ldr_req(ldr_req & ~sel), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(a_ldr_rdata), .ldr_ready(a_ldr_ready),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .gnt_ldr(a_gnt_ldr)
  );

  mips_mem_arbiter #(.AW(16), .DW(16), .LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req & sel), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready),
    .ldr_req(ldr_req & sel), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(b_ldr_rdata), .ldr_ready(b_ldr_ready),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .gnt_ldr(b_gnt_ldr)
  );

  assign s_cpu_rdata = sel ? b_cpu_rdata : a_cpu_rdata;
  assign s_ldr_rdata = sel ? b_ldr_rdata : a_ldr_rdata;
  assign s_cpu_ready = sel ? b_cpu_ready : a_cpu_ready;
  assign s_ldr_ready = sel ? b_ldr_ready : a_ldr_ready;
  assign s_mem_en    = sel ? b_mem_en    : a_mem_en;
  assign s_mem_we    = sel ? b_mem_we    : a_mem_we;
  assign s_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign s_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign s_gnt_ldr   = sel ? b_gnt_ldr   : a_gnt_ldr;

  assign a_mem_rdata = a_mem_en ? (written[a_mem_addr[7:0]] ? phys[a_mem_addr[7:0]] : init_val(a_mem_addr[7:0])) : 16'h0;
  assign b_mem_rdata = b_mem_en ? (written[b_mem_addr[7:0]] ? phys[b_mem_addr[7:0]] : init_val(b_mem_addr[7:0])) : 16'h0;

  // Shared memory array written by whichever instance is selected.
  always @(posedge clk) begin
    if (s_mem_en && s_mem_we) begin
      phys[s_mem_addr[7:0]]    <= s_mem_wdata;
      written[s_mem_addr[7:0]] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input bit p, input logic we, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    e.rdata = we ? last_rd[sel][p] : ref_mem[a[7:0]];
    if (we) ref_mem[a[7:0]] = d;
    else    last_rd[sel][p] = ref_mem[a[7:0]];
    if (p) begin
      ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
      lq.push_back(e);
    end else begin
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
      cq.push_back(e);
    end
  endtask

  task automatic wait_ready(input bit p, output int n);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (p ? s_ldr_ready : s_cpu_ready) break;
    end
    if (!(p ? s_ldr_ready : s_cpu_ready)) check(p ? "ldr_ready_timeout" : "cpu_ready_timeout", 0, 1);
  endtask

  task automatic port_run(input bit p, input int n, input int hold_pct);
    int          lat;
    logic [15:0] base;
    base = p ? 16'h0048 : 16'h0040;
    for (int k = 0; k < n; k++) begin
      issue(p, 1'($urandom_range(0, 1)), base + 16'($urandom_range(0, 7)), 16'($urandom));
      wait_ready(p, lat);
      if (k == n - 1 || $urandom_range(0, 99) >= hold_pct) begin
        if (p) ldr_req = 1'b0;
        else   cpu_req = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  task automatic clear_rd();
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) last_rd[i][j] = 16'h0;
  endtask

  task automatic monitor();
    int          run;
    logic [15:0] ma, md;
    logic        mw, mg, stable;
    exp_t        e;
    bit          p;
    run = 0; stable = 1'b1; ma = 0; md = 0; mw = 0; mg = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        run = 0; stable = 1'b1;
      end else begin
        if (s_mem_en) begin
          if (run == 0) begin
            ma = s_mem_addr; md = s_mem_wdata; mw = s_mem_we; mg = s_gnt_ldr;
          end else if (s_mem_addr !== ma || s_mem_wdata !== md || s_mem_we !== mw || s_gnt_ldr !== mg) begin
            stable = 1'b0;
          end
          run++;
        end
        if (s_cpu_ready && s_ldr_ready) begin
          check("both_ready", 1, 0);
        end else if (s_cpu_ready || s_ldr_ready) begin
          p = s_ldr_ready;
          if ((p ? lq.size() : cq.size()) == 0) begin
            check(p ? "ldr_spurious_ready" : "cpu_spurious_ready", 1, 0);
          end else begin
            e = p ? lq.pop_front() : cq.pop_front();
            check(p ? "ldr_rdata" : "cpu_rdata", p ? s_ldr_rdata : s_cpu_rdata, e.rdata);
            check("access_cycles", run, sel ? 3 : 1);
            check("mem_addr", ma, e.addr);
            check("mem_we", mw, e.we);
            if (e.we) check("mem_wdata", md, e.wdata);
            check("gnt_ldr", mg, p);
            check("fields_stable", stable, 1);
          end
          order.push_back(int'(p));
          rcyc.push_back(cyc);
          run = 0; stable = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int n, snap, ens;
    n_checks = 0; n_fails = 0; cyc = 0;
    sel = 1'b0; rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    clear_rd();
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_cpu_rdata", s_cpu_rdata, 0);
      check("rst_ldr_rdata", s_ldr_rdata, 0);
      check("rst_readies", {s_cpu_ready, s_ldr_ready}, 0);
      check("rst_mem_en_we", {s_mem_en, s_mem_we}, 0);
      check("rst_mem_addr", s_mem_addr, 0);
      check("rst_mem_wdata", s_mem_wdata, 0);
      check("rst_gnt_ldr", s_gnt_ldr, 0);
    end
    sel = 1'b0;
    @(negedge clk);

    issue(0, 1'b0, 16'h0004, 16'h0000);
    wait_ready(0, n);
    check("cpu_read_latency", n, 2);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("cpu_rdata_hold", s_cpu_rdata, 16'h1234);
    check("single_access_count", order.size(), 1);

    sel = 1'b1;
    issue(1, 1'b1, 16'h0010, 16'hBEEF);
    wait_ready(1, n);
    check("ldr_write_latency", n, 4);
    ldr_req = 1'b0;
    @(negedge clk);
    check("mem_written", phys[16], 16'hBEEF);

    sel = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; clear_rd();
    @(negedge clk);
    order.delete(); rcyc.delete();
    fork
      port_run(0, 4, 100);
      port_run(1, 4, 100);
    join
    check("tie_count", order.size(), 8);
    for (int i = 0; i < 8 && i < order.size(); i++) check("tie_order", order[i], i % 2);
    for (int i = 1; i < 8 && i < rcyc.size(); i++) check("tie_spacing", rcyc[i] - rcyc[i-1], 3);

    sel = 1'b1;
    @(negedge clk);
    issue(0, 1'b0, 16'h0020, 16'h0000);
    @(negedge clk);
    cpu_addr = 16'h0030;
    wait_ready(0, n);
    cpu_req = 1'b0;
    @(negedge clk);

    issue(0, 1'b1, 16'h0022, 16'hA5A5);
    @(negedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    wait_ready(0, n);
    check("drop_ready_latency", n, 2);
    snap = order.size(); ens = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_mem_en) ens++;
    end
    check("drop_no_extra_ready", order.size(), snap);
    check("drop_no_extra_access", ens, 0);

    issue(0, 1'b0, 16'h0024, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    check("mid_access_mem_en", s_mem_en, 1);
    rst = 1'b1;
    #1;
    check("rst_mem_en_drop", s_mem_en, 0);
    cq.delete(); lq.delete(); cpu_req = 1'b0; clear_rd();
    snap = order.size();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_ready", order.size(), snap);
    order.delete();
    fork
      port_run(0, 1, 0);
      port_run(1, 1, 0);
    join
    check("post_rst_tie_count", order.size(), 2);
    if (order.size() == 2) begin
      check("post_rst_first", order[0], 0);
      check("post_rst_second", order[1], 1);
    end

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      @(negedge clk);
      fork
        port_run(0, 15, 30);
        port_run(1, 15, 30);
      join
    end

    repeat (3) @(negedge clk);
    check("cpu_queue_drained", cq.size(), 0);
    check("ldr_queue_drained", lq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
